mips_instr_encoder: RTL

//  Encoder side of the single-cycle MIPS control path: turns field-level instruction requests (kind + register/immediate fields)

---
 rtl/mips_instr_encoder_pkg.sv | 27 ++
 rtl/mips_instr_encoder_if.sv | 22 ++
 rtl/mips_instr_encoder_pack.sv | 30 +++
 rtl/mips_instr_encoder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mips_instr_encoder_pkg.sv
// Shared types for the MIPS instruction encoder: request kinds, main-decoder opcodes, FSM states.
package mips_enc_pkg;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BEQ  = 3'd3,
    KIND_ADDI = 3'd4,
    KIND_J    = 3'd5
  } kindE;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } stateE;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request-beat channel into the encoder: valid/ready handshake plus instruction fields.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [5:0]  in_funct;
  logic [25:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/mips_instr_encoder_pack.sv
// Combinational packer: request kind + fields -> 32-bit MIPS word, with an illegal-kind flag.
module mips_instr_pack
  import mips_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (kind)
      KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
      KIND_LW:   word = {OP_LW,   rs, rt, imm[15:0]};
      KIND_SW:   word = {OP_SW,   rs, rt, imm[15:0]};
      KIND_BEQ:  word = {OP_BEQ,  rs, rt, imm[15:0]};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm[15:0]};
      KIND_J:    word = {OP_J,    imm};
      // Illegal kinds fall back to all-zero, which decodes as sll $0,$0,0.
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams encoded MIPS words into instruction memory at consecutive addresses.
// Optional ENCODER_CHECK_EN: drop illegal-kind beats and raise a sticky err flag.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  mips_instr_encoder_if.slave  reqIf,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          count,
  output logic                 err
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

  stateE         stateReg, stateNext;
  logic [AW-1:0] ptrReg;
  logic [AW:0]   countReg;
  logic          memWeReg;
  logic [AW-1:0] memAddrReg;
  logic [31:0]   memWdataReg;
  logic          inReady;
  logic          beatAccept;
  logic          beatWrite;
  logic          lastBeat;
  logic [31:0]   packedWord;
  logic          packedIllegal;

  mips_instr_pack packer (
    .kind    (reqIf.in_kind),
    .rs      (reqIf.in_rs),
    .rt      (reqIf.in_rt),
    .rd      (reqIf.in_rd),
    .funct   (reqIf.in_funct),
    .imm     (reqIf.in_imm),
    .word    (packedWord),
    .illegal (packedIllegal)
  );

  assign beatAccept = reqIf.in_valid & inReady;

`ifdef ENCODER_CHECK_EN
  logic errReg;
  assign beatWrite = beatAccept & ~packedIllegal;

  always_ff @(posedge clk) begin
    if (rst)
      errReg <= 1'b0;
    else if (stateReg == IDLE && start)
      errReg <= 1'b0;
    else if (beatAccept && packedIllegal)
      errReg <= 1'b1;
  end

  assign err = errReg;
`else
  logic unusedIllegal;
  assign unusedIllegal = packedIllegal;
  assign beatWrite     = beatAccept;
  assign err           = 1'b0;
`endif

  // A session ends on an accepted last beat or on the write that fills DEPTH.
  assign lastBeat = beatAccept &
                    (reqIf.in_last | (beatWrite & ((countReg + CNT_ONE) == DEPTH_CNT)));

  always_ff @(posedge clk) begin
    if (rst)
      stateReg <= IDLE;
    else
      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = LOAD;
      LOAD:    if (lastBeat) stateNext = FLUSH;
      FLUSH:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    inReady = (stateReg == LOAD);
    busy    = (stateReg != IDLE);
    done    = (stateReg == DONE);
  end

  assign reqIf.in_ready = inReady;

  // Output register stage: a beat accepted at cycle N is presented to memory at N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptrReg      <= '0;
      countReg    <= '0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
    end else begin
      memWeReg <= beatWrite;
      if (stateReg == IDLE && start) begin
        ptrReg   <= base_addr;
        countReg <= '0;
      end
      if (beatWrite) begin
        memAddrReg  <= ptrReg;
        memWdataReg <= packedWord;
        ptrReg      <= ptrReg + 1'b1;
        countReg    <= countReg + CNT_ONE;
      end
    end
  end

  assign mem_we    = memWeReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;
  assign count     = countReg;

endmodule
